board_matrix_driver: RTL and testbench

Renders the tic-tac-toe board vector onto the 8×8 dot-matrix display by row scanning. It is the reader side of the 18-bit `board` / 2-bit `result` interface written by the game-state block. It sits alongside the 7-segment turn indicator and owns `dot_row` / `dot_col` exclusively. The board is snapshotted once per frame so the display never tears, and the whole image blinks when a game result is set.

---
 rtl/board_matrix_driver_pkg.sv | 31 +++
 rtl/board_matrix_driver_if.sv | 13 +
 rtl/board_matrix_driver_tick_divider.sv | 28 ++
 rtl/board_matrix_driver.sv | 107 ++++++++++
 tb/tb_board_matrix_driver.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_matrix_driver_pkg.sv
// Shared definitions for the tic-tac-toe board interface and the dot-matrix renderer.
// Result codes, cell bit-index helpers and grid-line positions.
package board_matrix_driver_pkg;

  typedef enum logic [1:0] {
    RES_PLAY = 2'b00,
    RES_XWIN = 2'b01,
    RES_OWIN = 2'b10,
    RES_DRAW = 2'b11
  } result_e;

  typedef enum logic {
    PHASE_OFF = 1'b0,
    PHASE_ON  = 1'b1
  } phase_e;

  localparam logic [2:0]  GRID_ROW_A = 3'd2;
  localparam logic [2:0]  GRID_ROW_B = 3'd5;
  localparam int unsigned GRID_COL_A = 2;
  localparam int unsigned GRID_COL_B = 5;

  // Cell k runs 1..9; cell 1 occupies the top two bits of the board vector.
  function automatic int unsigned x_bit(input int unsigned k);
    return 18 - 2 * k;
  endfunction

  function automatic int unsigned o_bit(input int unsigned k);
    return 19 - 2 * k;
  endfunction

endpackage

// File: rtl/board_matrix_driver_if.sv
// Board/result inputs and dot-matrix outputs between game logic and the renderer.
interface board_matrix_driver_if;
  import board_matrix_driver_pkg::*;

  logic        enable;
  logic [17:0] board;
  result_e     result;
  logic [7:0]  dot_row;
  logic [7:0]  dot_col;

  modport master (output enable, board, result, input dot_row, dot_col);
  modport slave  (input enable, board, result, output dot_row, dot_col);
endinterface

// File: rtl/board_matrix_driver_tick_divider.sv
// Free-running 0..DIV-1 counter with a single-cycle tick on the wrap value.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/board_matrix_driver.sv
// Row-scanned 8x8 renderer of the tic-tac-toe board with per-frame snapshot
// and whole-image blinking while a game result is set.
module board_matrix_driver
  import board_matrix_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 25000,
  parameter int unsigned BLINK_DIV = 6250000
) (
  input logic                  clk,
  input logic                  rst,
  board_matrix_driver_if.slave mat
);

  logic        scan_tick, blink_tick, scan_clr, blink_clr;
  logic [2:0]  row_q, row_d;
  logic [17:0] snap_q, snap_d;
  logic [7:0]  pat_q, pat_d;
  logic [7:0]  dot_row_q, dot_row_d;
  logic [7:0]  dot_col_q, dot_col_d;
  phase_e      phase_q, phase_d;

  assign scan_clr  = ~mat.enable;
  assign blink_clr = ~mat.enable | (mat.result == RES_PLAY);

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk (clk), .rst (rst), .clr (scan_clr), .tick (scan_tick)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk (clk), .rst (rst), .clr (blink_clr), .tick (blink_tick)
  );

  function automatic logic [7:0] row_pattern(input logic [2:0] r, input logic [17:0] b);
    logic [7:0]  p;
    logic [17:0] sh;
    int unsigned i, s, k;
    p = '0;
    if (r == GRID_ROW_A || r == GRID_ROW_B) begin
      p = '1;
    end else begin
      p = (8'b1 << GRID_COL_A) | (8'b1 << GRID_COL_B);
      if (r >= 3'd6)      i = 2;
      else if (r >= 3'd3) i = 1;
      else                i = 0;
      s = {29'd0, r} - 3 * i;
      for (int unsigned j = 0; j < 3; j++) begin
        k  = 3 * i + j + 1;
        sh = b >> o_bit(k);
        if (sh[0]) begin
          p = p | (8'b11 << (3 * j));
        end else begin
          sh = b >> x_bit(k);
          if (sh[0]) p = p | (8'b1 << (3 * j + s));
        end
      end
    end
    return p;
  endfunction

  always_comb begin
    row_d     = row_q;
    snap_d    = snap_q;
    pat_d     = pat_q;
    dot_row_d = dot_row_q;
    phase_d   = phase_q;
    if (!mat.enable) begin
      row_d     = 3'd7;
      snap_d    = '0;
      pat_d     = '0;
      dot_row_d = '0;
      phase_d   = PHASE_ON;
    end else begin
      if (scan_tick) begin
        row_d = row_q + 3'd1;
        if (row_d == 3'd0) snap_d = mat.board;
        pat_d     = row_pattern(row_d, snap_d);
        dot_row_d = 8'b1 << row_d;
      end
      if (mat.result == RES_PLAY) phase_d = PHASE_ON;
      else if (blink_tick)        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
    end
    // pat_q keeps the unblanked row so a blink-on edge can restore it without a tick.
    dot_col_d = (phase_d == PHASE_ON) ? pat_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= 3'd7;
      snap_q    <= '0;
      pat_q     <= '0;
      dot_row_q <= '0;
      dot_col_q <= '0;
      phase_q   <= PHASE_ON;
    end else begin
      row_q     <= row_d;
      snap_q    <= snap_d;
      pat_q     <= pat_d;
      dot_row_q <= dot_row_d;
      dot_col_q <= dot_col_d;
      phase_q   <= phase_d;
    end
  end

  assign mat.dot_row = dot_row_q;
  assign mat.dot_col = dot_col_q;

endmodule

// File: tb/tb_board_matrix_driver.sv
// Self-checking bench for board_matrix_driver against a cycle-count image model.
module tb_board_matrix_driver;
  import board_matrix_driver_pkg::*;

  localparam int SD = 4;
  localparam int BD = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_matrix_driver_if mat();

  board_matrix_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .mat (mat)
  );

  int checks = 0;
  int errors = 0;

  // Model: clocks since scanning (re)started, clocks since the result went non-zero,
  // and the board seen on the most recent row-0 tick.
  int          n_m, mb_m;
  logic [17:0] snap_m;
  logic [7:0]  exp_row, exp_col;

  function automatic logic [7:0] image_row(input logic [17:0] b, input int r);
    logic [63:0] img;
    logic [63:0] t;
    logic [17:0] sh;
    logic        o, x;
    img = '0;
    for (int rr = 0; rr < 8; rr++)
      for (int cc = 0; cc < 8; cc++)
        if (rr == 2 || rr == 5 || cc == 2 || cc == 5) img = img | (64'd1 << (8 * rr + cc));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        sh = b >> (19 - 2 * (3 * i + j + 1)); o = sh[0];
        sh = b >> (18 - 2 * (3 * i + j + 1)); x = sh[0];
        for (int s = 0; s < 2; s++)
          for (int tt = 0; tt < 2; tt++)
            if (o || (x && s == tt)) img = img | (64'd1 << (8 * (3 * i + s) + 3 * j + tt));
      end
    t = img >> (8 * r);
    return t[7:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || !mat.enable) begin
      n_m    <= 0;
      mb_m   <= 0;
      snap_m <= '0;
    end else begin
      n_m  <= n_m + 1;
      mb_m <= (mat.result == RES_PLAY) ? 0 : mb_m + 1;
      if ((n_m + 1) % SD == 0 && (((n_m + 1) / SD) - 1) % 8 == 0) snap_m <= mat.board;
    end
  end

  always_comb begin
    int r;
    exp_row = '0;
    exp_col = '0;
    r = 0;
    if (n_m >= SD) begin
      r       = ((n_m / SD) - 1) % 8;
      exp_row = 8'b1 << r;
      exp_col = (((mb_m / BD) % 2) == 0) ? image_row(snap_m, r) : 8'h00;
    end
  end

  task automatic wait_row(input logic [7:0] target);
    logic [7:0] prev;
    bit found;
    prev  = mat.dot_row;
    found = 0;
    for (int i = 0; i < 20 * SD && !found; i++) begin
      @(negedge clk);
      if (mat.dot_row == target && prev != target) found = 1;
      prev = mat.dot_row;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_row: row %h never entered, last dot_row=%h", target, mat.dot_row);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mat.enable = 1'b1;
    mat.board  = '0;
    mat.result = RES_PLAY;
    #12;
    checks++;
    if (mat.dot_row !== 8'h00 || mat.dot_col !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: row=%h col=%h, required 00/00", mat.dot_row, mat.dot_col);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= SD; i++) begin
      @(negedge clk);
      checks++;
      if (i < SD && (mat.dot_row !== 8'h00 || mat.dot_col !== 8'h00)) begin
        errors++;
        $display("FAIL first_tick_early: clk %0d row=%h col=%h, required 00/00", i, mat.dot_row, mat.dot_col);
      end else if (i == SD && (mat.dot_row !== 8'h01 || mat.dot_col !== 8'h24)) begin
        errors++;
        $display("FAIL first_row0: row=%h col=%h, required 01/24", mat.dot_row, mat.dot_col);
      end
    end
    repeat (2 * SD) @(negedge clk);
    checks++;
    if (mat.dot_row !== 8'h04 || mat.dot_col !== 8'hFF) begin
      errors++;
      $display("FAIL grid_row2: row=%h col=%h, required 04/FF", mat.dot_row, mat.dot_col);
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 16 * SD; i++) begin
      @(negedge clk);
      checks++;
      if (mat.dot_row !== exp_row || mat.dot_col !== exp_col) begin
        errors++;
        $display("FAIL scan cyc%0d: row=%h col=%h, required %h/%h", i, mat.dot_row, mat.dot_col, exp_row, exp_col);
      end
    end
  endtask

  task automatic test_snapshot();
    mat.board = 18'h20000;
    wait_row(8'h01);
    checks++;
    if (mat.dot_col !== 8'h27) begin errors++; $display("FAIL snap_o_row0: col=%h, required 27", mat.dot_col); end
    wait_row(8'h02);
    checks++;
    if (mat.dot_col !== 8'h27) begin errors++; $display("FAIL snap_o_row1: col=%h, required 27", mat.dot_col); end
    mat.board = 18'h10000;
    wait_row(8'h01);
    checks++;
    if (mat.dot_col !== 8'h25) begin errors++; $display("FAIL snap_x_row0: col=%h, required 25", mat.dot_col); end
    wait_row(8'h02);
    checks++;
    if (mat.dot_col !== 8'h26) begin errors++; $display("FAIL snap_x_row1: col=%h, required 26", mat.dot_col); end
  endtask

  task automatic test_priority();
    mat.board = 18'h00003;
    wait_row(8'h01);
    wait_row(8'h40);
    checks++;
    if (mat.dot_col !== 8'hE4) begin errors++; $display("FAIL prio_row6: col=%h, required E4", mat.dot_col); end
    wait_row(8'h80);
    checks++;
    if (mat.dot_col !== 8'hE4) begin errors++; $display("FAIL prio_row7: col=%h, required E4", mat.dot_col); end
  endtask

  task automatic test_midframe();
    logic [17:0] b1, b2;
    b1 = 18'($urandom);
    b2 = ~b1;
    mat.board = b1;
    wait_row(8'h01);
    wait_row(8'h08);
    mat.board = b2;
    for (int r = 4; r < 8; r++) begin
      wait_row(8'h01 << r);
      checks++;
      if (mat.dot_col !== image_row(b1, r)) begin
        errors++;
        $display("FAIL midframe_old row%0d: col=%h, required %h", r, mat.dot_col, image_row(b1, r));
      end
    end
    for (int r = 0; r < 8; r++) begin
      wait_row(8'h01 << r);
      checks++;
      if (mat.dot_col !== image_row(b2, r)) begin
        errors++;
        $display("FAIL midframe_new row%0d: col=%h, required %h", r, mat.dot_col, image_row(b2, r));
      end
    end
  endtask

  task automatic test_blink();
    int zeros;
    zeros = 0;
    mat.result = RES_XWIN;
    for (int i = 0; i < 4 * BD; i++) begin
      @(negedge clk);
      if (mat.dot_col == 8'h00) zeros++;
      checks++;
      if (mat.dot_row !== exp_row || mat.dot_col !== exp_col) begin
        errors++;
        $display("FAIL blink cyc%0d: row=%h col=%h, required %h/%h", i, mat.dot_row, mat.dot_col, exp_row, exp_col);
      end
    end
    checks++;
    if (zeros != 2 * BD) begin
      errors++;
      $display("FAIL blink_dark_count: %0d blank clocks, required %0d", zeros, 2 * BD);
    end
    repeat (100) @(negedge clk);
    mat.result = RES_PLAY;
    @(negedge clk);
    checks++;
    if (mat.dot_col === 8'h00 || mat.dot_col !== exp_col) begin
      errors++;
      $display("FAIL blink_restore: col=%h, required %h (non-zero)", mat.dot_col, exp_col);
    end
  endtask

  task automatic test_enable_reset();
    wait_row(8'h08);
    mat.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mat.dot_row !== 8'h00 || mat.dot_col !== 8'h00) begin
        errors++;
        $display("FAIL enable_low clk%0d: row=%h col=%h, required 00/00", i, mat.dot_row, mat.dot_col);
      end
    end
    mat.enable = 1'b1;
    repeat (SD) @(negedge clk);
    checks++;
    if (mat.dot_row !== 8'h01 || mat.dot_col !== image_row(mat.board, 0)) begin
      errors++;
      $display("FAIL enable_restart: row=%h col=%h, required 01/%h", mat.dot_row, mat.dot_col, image_row(mat.board, 0));
    end
    wait_row(8'h10);
    rst = 1'b1;
    #1;
    checks++;
    if (mat.dot_row !== 8'h00 || mat.dot_col !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: row=%h col=%h, required 00/00", mat.dot_row, mat.dot_col);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (SD - 1) @(negedge clk);
    checks++;
    if (mat.dot_row !== 8'h00) begin errors++; $display("FAIL reset_restart_early: row=%h, required 00", mat.dot_row); end
    @(negedge clk);
    checks++;
    if (mat.dot_row !== 8'h01 || mat.dot_col !== image_row(mat.board, 0)) begin
      errors++;
      $display("FAIL reset_restart: row=%h col=%h, required 01/%h", mat.dot_row, mat.dot_col, image_row(mat.board, 0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      checks++;
      if (mat.dot_row !== exp_row || mat.dot_col !== exp_col) begin
        errors++;
        $display("FAIL random cyc%0d: row=%h col=%h, required %h/%h", i, mat.dot_row, mat.dot_col, exp_row, exp_col);
      end
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) mat.enable = ~mat.enable;
      if ($urandom_range(0, 49) == 0)  mat.board  = 18'($urandom);
      if ($urandom_range(0, 299) == 0) mat.result = result_e'($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_priority();
    test_midframe();
    test_blink();
    test_enable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", checks);
    $fatal(1);
  end

endmodule
